ecc_field_op_sequencer: RTL and testbench

Sequences one field-operation instruction at a time into the ECC field-arithmetic datapath that owns RAMs A/B/C/D, the squarer/XOR unit and the MUL/RED path. The block sits directly upstream of that datapath. It accepts an instruction over a valid/ready handshake and drives the cycle-by-cycle controls: command strobes, select_line, byte_pos, RAM addresses and write enables. It pulses done when the result is written.

---
 rtl/ecc_field_op_sequencer_pkg.sv | 59 +++++
 rtl/ecc_field_op_sequencer_seq_cycle_counter.sv | 39 +++
 rtl/ecc_field_op_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_ecc_field_op_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_field_op_sequencer_pkg.sv
// Shared definitions for the ECC field-operation sequencer: opcodes,
// arithmetic-unit select codes, FSM state encoding, vector indices and
// opcode classification helpers.
package ecc_field_op_sequencer_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 8;

    // Instruction opcodes
    localparam logic [OP_W-1:0] OP_MUL  = 3'b001;
    localparam logic [OP_W-1:0] OP_SQR  = 3'b010;
    localparam logic [OP_W-1:0] OP_RED  = 3'b100;
    localparam logic [OP_W-1:0] OP_SWAP = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b111;

    // select_line codes for the arithmetic unit
    localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;
    localparam logic [SEL_W-1:0] SEL_MUL  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_SQR  = 3'b010;
    localparam logic [SEL_W-1:0] SEL_RED  = 3'b100;
    localparam logic [SEL_W-1:0] SEL_XOR  = 3'b111;

    // Bit positions inside the internal command-strobe vector
    localparam int unsigned CMD_SQR  = 0;
    localparam int unsigned CMD_MUL  = 1;
    localparam int unsigned CMD_RED  = 2;
    localparam int unsigned CMD_SWAP = 3;
    localparam int unsigned CMD_XOR  = 4;
    localparam int unsigned CMD_W    = 5;

    // RAM indices inside the internal address / write-enable vectors
    localparam int unsigned RAM_A = 0;
    localparam int unsigned RAM_B = 1;
    localparam int unsigned RAM_C = 2;
    localparam int unsigned RAM_D = 3;
    localparam int unsigned RAM_N = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // True for the five opcodes the datapath understands
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_SQR) || (op == OP_RED) ||
               (op == OP_SWAP) || (op == OP_XOR);
    endfunction

    // MUL and RED run through HOLD instead of RD/WAIT
    function automatic logic op_is_long(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_RED);
    endfunction

endpackage

// File: rtl/ecc_field_op_sequencer_seq_cycle_counter.sv
// seq_cycle_counter: 8-bit loadable down-counter with a zero flag, used to
// time the WAIT (read latency) and HOLD (multiplier) phases.
// Ports: clk, rst_n (sync, active-low), load/load_val (load a new count),
//        dec (decrement, saturating at zero), zero_c (count is zero).
module seq_cycle_counter
    import ecc_field_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Load has priority over decrement; decrement stops at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/ecc_field_op_sequencer.sv
// ecc_field_op_sequencer: accepts one field-arithmetic instruction at a time
// over valid/ready and drives the datapath controls (command strobes,
// select_line, byte_pos_A, RAM addresses and write enables) cycle by cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     instruction handshake
//   in_op, in_src_a, in_src_b, in_dst, in_cd_sel   instruction fields
//   cmd_*                 datapath command strobes (cmd_inv tied low)
//   select_line, byte_pos_A                        arithmetic unit selects
//   b_adbus_A..D, b_w_A..D                         RAM addresses / write enables
//   select_Ram_C/D        SWAP source select
//   busy, done, err       status: in flight, completion pulse, illegal-op pulse
// All outputs are registered from the next state, so a value computed when
// the FSM moves into a state is visible for exactly the cycles of that state.
module ecc_field_op_sequencer
    import ecc_field_op_sequencer_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned MUL_CYCLES = 8,
    parameter int unsigned ADDR       = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [ADDR-1:0] in_src_a,
    input  logic [ADDR-1:0] in_src_b,
    input  logic [ADDR-1:0] in_dst,
    input  logic            in_cd_sel,
    output logic            cmd_sqr,
    output logic            cmd_mul,
    output logic            cmd_red,
    output logic            cmd_swap,
    output logic            cmd_xor,
    output logic            cmd_inv,
    output logic [2:0]      select_line,
    output logic [1:0]      byte_pos_A,
    output logic [ADDR-1:0] b_adbus_A,
    output logic [ADDR-1:0] b_adbus_B,
    output logic [ADDR-1:0] b_adbus_C,
    output logic [ADDR-1:0] b_adbus_D,
    output logic            b_w_A,
    output logic            b_w_B,
    output logic            b_w_C,
    output logic            b_w_D,
    output logic            select_Ram_C,
    output logic            select_Ram_D,
    output logic            busy,
    output logic            done,
    output logic            err
);

    // FSM state and latched instruction
    state_t            state_d, state_q;
    logic [OP_W-1:0]   op_d, op_q;
    logic [ADDR-1:0]   src_a_d, src_a_q;
    logic [ADDR-1:0]   src_b_d, src_b_q;
    logic [ADDR-1:0]   dst_d, dst_q;
    logic              cd_sel_d, cd_sel_q;
    logic              pass_d, pass_q;

    // Cycle counter controls
    logic              cnt_load_c;
    logic [CNT_W-1:0]  cnt_load_val_c;
    logic              cnt_dec_c;
    logic              cnt_zero_c;
    logic              err_c;

    // Registered outputs
    logic                          in_ready_d, in_ready_q;
    logic                          busy_d, busy_q;
    logic                          done_d, done_q;
    logic                          err_d, err_q;
    logic [CMD_W-1:0]              cmd_d, cmd_q;
    logic [SEL_W-1:0]              sel_d, sel_q;
    logic [1:0]                    byte_pos_d, byte_pos_q;
    logic [RAM_N-1:0][ADDR-1:0]    adbus_d, adbus_q;
    logic [RAM_N-1:0]              we_d, we_q;
    logic [1:0]                    sel_ram_d, sel_ram_q;

    logic                          active_c;
    logic                          wr_c;
    logic [ADDR-1:0]               res_addr_c;

    seq_cycle_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .load_val (cnt_load_val_c),
        .dec      (cnt_dec_c),
        .zero_c   (cnt_zero_c)
    );

    // State and instruction registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            cd_sel_q <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            cd_sel_q <= cd_sel_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state logic, instruction capture and counter control
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        src_a_d        = src_a_q;
        src_b_d        = src_b_q;
        dst_d          = dst_q;
        cd_sel_d       = cd_sel_q;
        pass_d         = pass_q;
        cnt_load_c     = 1'b0;
        cnt_load_val_c = '0;
        cnt_dec_c      = 1'b0;
        err_c          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (op_is_legal(in_op)) begin
                        op_d     = in_op;
                        src_a_d  = in_src_a;
                        src_b_d  = in_src_b;
                        dst_d    = in_dst;
                        cd_sel_d = in_cd_sel;
                        pass_d   = 1'b0;
                        if (op_is_long(in_op)) begin
                            state_d        = ST_HOLD;
                            cnt_load_c     = 1'b1;
                            cnt_load_val_c = CNT_W'(MUL_CYCLES - 1);
                        end else begin
                            state_d = ST_RD;
                        end
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            ST_RD: begin
                state_d        = ST_WAIT;
                cnt_load_c     = 1'b1;
                cnt_load_val_c = CNT_W'(READ_LAT - 1);
            end
            ST_WAIT, ST_HOLD: begin
                if (cnt_zero_c) begin
                    state_d = ST_WR;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            ST_WR: begin
                // SQR needs a second pass for the upper half
                if ((op_q == OP_SQR) && !pass_q) begin
                    state_d = ST_RD;
                    pass_d  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SQR pass 1 writes the word after dst, wrapping within the RAM
    assign res_addr_c = dst_d + ADDR'(pass_d);

    // Output decode for the state being entered
    always_comb begin
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        err_d      = err_c;
        cmd_d      = '0;
        sel_d      = SEL_NONE;
        byte_pos_d = '0;
        adbus_d    = '0;
        we_d       = '0;
        sel_ram_d  = '0;
        active_c   = (state_d == ST_RD) || (state_d == ST_WAIT) ||
                     (state_d == ST_WR) || (state_d == ST_HOLD);
        wr_c       = (state_d == ST_WR);

        if (active_c) begin
            case (op_d)
                OP_XOR: begin
                    cmd_d[CMD_XOR]  = 1'b1;
                    sel_d           = SEL_XOR;
                    adbus_d[RAM_A]  = src_a_d;
                    adbus_d[RAM_B]  = src_b_d;
                end
                OP_SQR: begin
                    cmd_d[CMD_SQR]  = 1'b1;
                    sel_d           = SEL_SQR;
                    adbus_d[RAM_A]  = src_a_d;
                    byte_pos_d      = {1'b0, pass_d};
                end
                OP_MUL: begin
                    cmd_d[CMD_MUL]  = 1'b1;
                    sel_d           = SEL_MUL;
                    adbus_d[RAM_A]  = src_a_d;
                    adbus_d[RAM_B]  = src_b_d;
                end
                OP_RED: begin
                    cmd_d[CMD_RED]  = 1'b1;
                    sel_d           = SEL_RED;
                    adbus_d[RAM_A]  = src_a_d;
                    adbus_d[RAM_B]  = src_b_d;
                end
                OP_SWAP: begin
                    cmd_d[CMD_SWAP] = 1'b1;
                    adbus_d[RAM_A]  = dst_d;
                    adbus_d[RAM_B]  = dst_d;
                end
                default: begin
                end
            endcase

            // SWAP reads C/D and writes A+B; everything else writes C/D
            if (op_d == OP_SWAP) begin
                if (cd_sel_d) begin
                    sel_ram_d[1]   = 1'b1;
                    adbus_d[RAM_D] = src_a_d;
                end else begin
                    sel_ram_d[0]   = 1'b1;
                    adbus_d[RAM_C] = src_a_d;
                end
                we_d[RAM_A] = wr_c;
                we_d[RAM_B] = wr_c;
            end else if (cd_sel_d) begin
                adbus_d[RAM_D] = res_addr_c;
                we_d[RAM_D]    = wr_c;
            end else begin
                adbus_d[RAM_C] = res_addr_c;
                we_d[RAM_C]    = wr_c;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cmd_q      <= '0;
            sel_q      <= '0;
            byte_pos_q <= '0;
            adbus_q    <= '0;
            we_q       <= '0;
            sel_ram_q  <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cmd_q      <= cmd_d;
            sel_q      <= sel_d;
            byte_pos_q <= byte_pos_d;
            adbus_q    <= adbus_d;
            we_q       <= we_d;
            sel_ram_q  <= sel_ram_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cmd_sqr      = cmd_q[CMD_SQR];
    assign cmd_mul      = cmd_q[CMD_MUL];
    assign cmd_red      = cmd_q[CMD_RED];
    assign cmd_swap     = cmd_q[CMD_SWAP];
    assign cmd_xor      = cmd_q[CMD_XOR];
    assign cmd_inv      = 1'b0;
    assign select_line  = sel_q;
    assign byte_pos_A   = byte_pos_q;
    assign b_adbus_A    = adbus_q[RAM_A];
    assign b_adbus_B    = adbus_q[RAM_B];
    assign b_adbus_C    = adbus_q[RAM_C];
    assign b_adbus_D    = adbus_q[RAM_D];
    assign b_w_A        = we_q[RAM_A];
    assign b_w_B        = we_q[RAM_B];
    assign b_w_C        = we_q[RAM_C];
    assign b_w_D        = we_q[RAM_D];
    assign select_Ram_C = sel_ram_q[0];
    assign select_Ram_D = sel_ram_q[1];

endmodule

// File: tb/tb_ecc_field_op_sequencer.sv
// Self-checking bench for ecc_field_op_sequencer. A cycle-indexed reference
// model derived from the instruction timing rules predicts every output for
// each cycle after acceptance; directed and random instructions are compared
// against it.
module tb_ecc_field_op_sequencer;

    localparam int RL = 1;
    localparam int MC = 8;

    typedef struct packed {
        logic       in_ready, busy, done, err;
        logic       sqr, mul, red, swp, xr, inv;
        logic [2:0] sel;
        logic [1:0] bp;
        logic [2:0] a, b, c, d;
        logic       wa, wb, wc, wd;
        logic       sc, sd;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op, in_src_a, in_src_b, in_dst;
    logic       in_cd_sel;
    logic       cmd_sqr, cmd_mul, cmd_red, cmd_swap, cmd_xor, cmd_inv;
    logic [2:0] select_line;
    logic [1:0] byte_pos_A;
    logic [2:0] b_adbus_A, b_adbus_B, b_adbus_C, b_adbus_D;
    logic       b_w_A, b_w_B, b_w_C, b_w_D;
    logic       select_Ram_C, select_Ram_D;
    logic       busy, done, err;

    int checks   = 0;
    int failures = 0;

    outs_t obs;

    always #5 clk = ~clk;

    ecc_field_op_sequencer #(.READ_LAT(RL), .MUL_CYCLES(MC), .ADDR(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_dst(in_dst), .in_cd_sel(in_cd_sel),
        .cmd_sqr(cmd_sqr), .cmd_mul(cmd_mul), .cmd_red(cmd_red),
        .cmd_swap(cmd_swap), .cmd_xor(cmd_xor), .cmd_inv(cmd_inv),
        .select_line(select_line), .byte_pos_A(byte_pos_A),
        .b_adbus_A(b_adbus_A), .b_adbus_B(b_adbus_B),
        .b_adbus_C(b_adbus_C), .b_adbus_D(b_adbus_D),
        .b_w_A(b_w_A), .b_w_B(b_w_B), .b_w_C(b_w_C), .b_w_D(b_w_D),
        .select_Ram_C(select_Ram_C), .select_Ram_D(select_Ram_D),
        .busy(busy), .done(done), .err(err)
    );

    assign obs = outs_t'({in_ready, busy, done, err,
                          cmd_sqr, cmd_mul, cmd_red, cmd_swap, cmd_xor, cmd_inv,
                          select_line, byte_pos_A,
                          b_adbus_A, b_adbus_B, b_adbus_C, b_adbus_D,
                          b_w_A, b_w_B, b_w_C, b_w_D,
                          select_Ram_C, select_Ram_D});

    function automatic bit legal(input logic [2:0] op);
        return op == 3'b001 || op == 3'b010 || op == 3'b100 ||
               op == 3'b101 || op == 3'b111;
    endfunction

    // Cycle (counted from the accept edge) on which done is shown
    function automatic int done_cycle(input logic [2:0] op);
        if (op == 3'b010) return 5 + 2 * RL;
        if (op == 3'b001 || op == 3'b100) return MC + 2;
        return 3 + RL;
    endfunction

    // Expected outputs on cycle c after acceptance of a legal instruction
    function automatic outs_t model(input logic [2:0] op, input logic [2:0] sa,
                                    input logic [2:0] sb, input logic [2:0] dst,
                                    input logic cd, input int c);
        outs_t      e;
        int         t;
        logic       wr, half;
        logic [2:0] da;
        e = '0;
        t = done_cycle(op);
        if (c > t) begin
            e.in_ready = 1'b1;
            return e;
        end
        e.busy = 1'b1;
        if (c == t) begin
            e.done = 1'b1;
            return e;
        end
        if (op == 3'b010)                     wr = (c == 2 + RL) || (c == 4 + 2 * RL);
        else if (op == 3'b001 || op == 3'b100) wr = (c == MC + 1);
        else                                  wr = (c == 2 + RL);
        half = (op == 3'b010) && (c >= 3 + RL);
        da   = dst + {2'b00, half};
        case (op)
            3'b111: begin e.xr  = 1'b1; e.sel = 3'b111; e.a = sa; e.b = sb; end
            3'b010: begin e.sqr = 1'b1; e.sel = 3'b010; e.a = sa; e.bp = {1'b0, half}; end
            3'b001: begin e.mul = 1'b1; e.sel = 3'b001; e.a = sa; e.b = sb; end
            3'b100: begin e.red = 1'b1; e.sel = 3'b100; e.a = sa; e.b = sb; end
            default: begin
                e.swp = 1'b1; e.a = dst; e.b = dst; e.wa = wr; e.wb = wr;
                if (cd) begin e.sd = 1'b1; e.d = sa; end
                else    begin e.sc = 1'b1; e.c = sa; end
            end
        endcase
        if (op != 3'b101) begin
            if (cd) begin e.d = da; e.wd = wr; end
            else    begin e.c = da; e.wc = wr; end
        end
        return e;
    endfunction

    task automatic check(input string tag, input int c, input outs_t e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for in_ready, then present the instruction for one edge
    task automatic start(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] dst, input logic cd);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            failures++;
            $error("FAIL ready_timeout observed=%b expected=1", in_ready);
        end
        in_op = op; in_src_a = sa; in_src_b = sb; in_dst = dst; in_cd_sel = cd;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic check_run(input string tag, input logic [2:0] op, input logic [2:0] sa,
                             input logic [2:0] sb, input logic [2:0] dst, input logic cd);
        int t;
        t = done_cycle(op);
        for (int c = 1; c <= t + 1; c++) begin
            check(tag, c, model(op, sa, sb, dst, cd, c));
            if (c <= t) tick();
        end
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic [2:0] sa,
                             input logic [2:0] sb, input logic [2:0] dst, input logic cd);
        outs_t e;
        start(op, sa, sb, dst, cd);
        in_valid = 1'b0;
        if (legal(op)) begin
            check_run(tag, op, sa, sb, dst, cd);
        end else begin
            e = '0; e.in_ready = 1'b1; e.err = 1'b1;
            check({tag, "_err"}, 1, e);
            tick();
            e.err = 1'b0;
            check({tag, "_after_err"}, 2, e);
        end
    endtask

    initial begin
        outs_t e;
        logic [2:0] rop;
        rst_n = 1'b0; in_valid = 1'b0;
        in_op = '0; in_src_a = '0; in_src_b = '0; in_dst = '0; in_cd_sel = 1'b0;

        // Reset held for three cycles: every output low
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset", i, '0);
        end
        rst_n = 1'b1;
        tick();
        e = '0; e.in_ready = 1'b1;
        check("post_reset", 0, e);

        run_instr("xor_dir",  3'b111, 3'd2, 3'd5, 3'd3, 1'b0);
        // Back-to-back XOR accepted on the cycle in_ready returns
        run_instr("xor_b2b",  3'b111, 3'd6, 3'd1, 3'd0, 1'b1);
        run_instr("sqr_wrap", 3'b010, 3'd1, 3'd0, 3'd7, 1'b1);

        // MUL with in_valid held for a following XOR throughout busy
        start(3'b001, 3'd4, 3'd2, 3'd5, 1'b0);
        in_op = 3'b111; in_src_a = 3'd3; in_src_b = 3'd4; in_dst = 3'd1; in_cd_sel = 1'b1;
        check_run("mul_held", 3'b001, 3'd4, 3'd2, 3'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        check_run("xor_after_held", 3'b111, 3'd3, 3'd4, 3'd1, 1'b1);

        run_instr("illegal0", 3'b000, 3'd1, 3'd2, 3'd3, 1'b0);
        run_instr("swap_c",   3'b101, 3'd4, 3'd0, 3'd6, 1'b0);
        run_instr("swap_d",   3'b101, 3'd7, 3'd0, 3'd2, 1'b1);
        run_instr("red_d",    3'b100, 3'd0, 3'd7, 3'd4, 1'b1);
        run_instr("illegal6", 3'b110, 3'd0, 3'd0, 3'd0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_instr("rand", rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        // Reset during cycle 2 of an XOR: instruction dropped, nothing written
        start(3'b111, 3'd2, 3'd5, 3'd3, 1'b0);
        in_valid = 1'b0;
        check("rst_mid_c1", 1, model(3'b111, 3'd2, 3'd5, 3'd3, 1'b0, 1));
        tick();
        check("rst_mid_c2", 2, model(3'b111, 3'd2, 3'd5, 3'd3, 1'b0, 2));
        rst_n = 1'b0;
        tick();
        check("rst_mid_clear", 3, '0);
        rst_n = 1'b1;
        e = '0; e.in_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_mid_idle", 4 + i, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
